// File: rtl/uart_rx_word_ctrl.sv
// RX FIFO drain controller: packs received bytes little-endian into 32-bit words,
// flushes partial words on character timeout, tracks sticky errors and drives the irq.
module uart_rx_word_ctrl #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int TMR_W          = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable_i,
  input  logic [7:0]  rx_d_i,
  input  logic        rx_d_valid_i,
  output logic        rx_d_ready_o,
  output logic [31:0] word_o,
  output logic [2:0]  word_bytes_o,
  output logic        word_valid_o,
  input  logic        word_ready_i,
  input  logic        frame_err_i,
  input  logic        parity_err_i,
  input  logic        overrun_err_i,
  input  logic [2:0]  err_clr_i,
  output logic [2:0]  err_sticky_o,
  input  logic        flush_i,
  output logic        flush_rx_o,
  input  logic        irq_word_en_i,
  input  logic        irq_err_en_i,
  output logic        irq_o
);

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_OUT} state_e;

  localparam logic [TMR_W-1:0] TMR_EXP = TMR_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic [TMR_W-1:0] TMR_SAT = TMR_W'(TIMEOUT_CYCLES);

  state_e                state_q, state_d;
  logic [3:0][7:0]       word_q, word_d;
  logic [2:0]            bytes_q, bytes_d;
  logic                  valid_q, valid_d;
  logic [2:0]            cnt_q, cnt_d;
  logic [TMR_W-1:0]      tmr_q, tmr_d;
  logic [2:0]            err_q, err_d;
  logic                  flush_q;
  logic                  irq_q, irq_d;
  logic                  accept;

  // Gated with rst_n so ready reads low while reset is held, like every other output.
  assign rx_d_ready_o = rst_n & enable_i & (state_q != S_OUT) & ~flush_i;
  assign accept       = rx_d_valid_i & rx_d_ready_o;

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    bytes_d = bytes_q;
    valid_d = valid_q;
    cnt_d   = cnt_q;
    tmr_d   = tmr_q;
    err_d   = (err_q & ~err_clr_i) | {overrun_err_i, parity_err_i, frame_err_i};

    if (flush_i) begin
      // Flush discards everything held, including a word still awaiting handshake.
      state_d = S_IDLE;
      word_d  = '0;
      bytes_d = '0;
      valid_d = 1'b0;
      cnt_d   = '0;
      tmr_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            word_d[0] = rx_d_i;
            cnt_d     = 3'd1;
            tmr_d     = '0;
            state_d   = S_FILL;
          end
        end
        S_FILL: begin
          if (accept) begin
            word_d[cnt_q[1:0]] = rx_d_i;
            tmr_d              = '0;
            if (cnt_q == 3'd3) begin
              cnt_d   = 3'd4;
              bytes_d = 3'd4;
              valid_d = 1'b1;
              state_d = S_OUT;
            end else begin
              cnt_d = cnt_q + 3'd1;
            end
          end else if (TIMEOUT_CYCLES > 0 && tmr_q == TMR_EXP) begin
            bytes_d = cnt_q;
            valid_d = 1'b1;
            state_d = S_OUT;
          end else if (TIMEOUT_CYCLES > 0 && tmr_q != TMR_SAT) begin
            tmr_d = tmr_q + 1'b1;
          end
        end
        S_OUT: begin
          if (word_ready_i) begin
            state_d = S_IDLE;
            word_d  = '0;
            bytes_d = '0;
            valid_d = 1'b0;
            cnt_d   = '0;
            tmr_d   = '0;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    irq_d = (irq_word_en_i & valid_d) | (irq_err_en_i & (|err_d));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      word_q  <= '0;
      bytes_q <= '0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
      tmr_q   <= '0;
      err_q   <= '0;
      flush_q <= 1'b0;
      irq_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      bytes_q <= bytes_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
      tmr_q   <= tmr_d;
      err_q   <= err_d;
      flush_q <= flush_i;
      irq_q   <= irq_d;
    end
  end

  assign word_o       = word_q;
  assign word_bytes_o = bytes_q;
  assign word_valid_o = valid_q;
  assign err_sticky_o = err_q;
  assign flush_rx_o   = flush_q;
  assign irq_o        = irq_q;

endmodule

// File: doc/uart_rx_word_ctrl.md
Name: uart_rx_word_ctrl

Overview:
Controller on the clk-domain side of the UART RX FIFO. It drains received bytes through the FIFO dequeue handshake and packs them little-endian into 32-bit words. A partial word is flushed when a character timeout expires. It also keeps sticky RX error flags, drives the interrupt line, and sequences RX FIFO flushes for the register block.

Parameters:
TIMEOUT_CYCLES, 64, idle clk cycles after the last accepted byte before a partial word is emitted; 0 disables the timeout.
TMR_W, $clog2(TIMEOUT_CYCLES+1) (minimum 1), width of the timeout counter.

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous, active-low reset
enable_i  input  1  allow draining of the RX FIFO
rx_d_i  input  8  byte from RX FIFO
rx_d_valid_i  input  1  FIFO byte valid
rx_d_ready_o  output  1  byte accepted when valid&ready
word_o  output  32  packed word; byte0 in [7:0]; unused bytes zero
word_bytes_o  output  3  number of valid bytes in word_o, 1..4
word_valid_o  output  1  word available
word_ready_i  input  1  consumer accepts word
frame_err_i  input  1  frame-length error pulse (clk domain)
parity_err_i  input  1  parity error pulse (clk domain)
overrun_err_i  input  1  overrun error pulse (clk domain)
err_clr_i  input  3  W1C clear {overrun, parity, frame}
err_sticky_o  output  3  sticky {overrun, parity, frame}
flush_i  input  1  software flush request (pulse)
flush_rx_o  output  1  one-cycle flush pulse to RX FIFO
irq_word_en_i  input  1  interrupt enable, word ready
irq_err_en_i  input  1  interrupt enable, errors
irq_o  output  1  interrupt, level

Behaviour:
- Reset values: state IDLE; word_o=0; word_bytes_o=0; word_valid_o=0; err_sticky_o=0; flush_rx_o=0; irq_o=0; rx_d_ready_o=0; byte count=0; timer=0.
- States:
  - IDLE: 0 bytes held.
  - FILL: 1..3 bytes held.
  - OUT: word presented.
- rx_d_ready_o = enable_i & (state != OUT) & ~flush_i.
- Byte accept (valid&ready): byte written to word_o[8*cnt +: 8]; cnt increments; timer cleared to 0.
  - IDLE -> FILL.
  - FILL stays in FILL while cnt < 3.
  - If this is the 4th byte: -> OUT with word_bytes_o=4. word_valid_o is high on the clock edge after the 4th accept (1-cycle latency).
- Timeout, FILL only, TIMEOUT_CYCLES>0:
  - Timer increments each FILL cycle with no accept; saturates, no wrap.
  - On a cycle with timer==TIMEOUT_CYCLES-1 and no accept: -> OUT with word_bytes_o=cnt.
  - Result: word_valid_o rises exactly TIMEOUT_CYCLES edges after the last accept edge.
  - An accept on the expiry cycle wins: the byte is packed and the timer is cleared.
- enable_i low: no accepts. Held bytes remain and the timer keeps running, so the partial word still times out.
- OUT:
  - word_o and word_bytes_o are stable while word_valid_o=1 and word_ready_i=0.
  - On word_valid_o & word_ready_i: -> IDLE; word_o cleared to 0; cnt=0; word_bytes_o=0. No byte is accepted in that cycle.
- Sticky errors:
  - Bit sets on the edge after its pulse.
  - err_clr_i bit clears it.
  - A set and a clear in the same cycle: set wins.
- irq_o = (irq_word_en_i & word_valid_o) | (irq_err_en_i & |err_sticky_o). Driven from flops only, no input-to-output combinational path.
- Flush:
  - flush_i in any state -> IDLE next edge. The partial word and any pending word_valid_o are discarded; cnt and timer go to 0.
  - flush_rx_o pulses for exactly 1 cycle, on the edge after flush_i.
  - Sticky errors are not affected.
  - flush_i held high for N cycles produces N pulses.
- Simultaneous flush_i and word handshake: flush wins; the word is treated as consumed.
- Reset asserted mid-operation: all state clears immediately and asynchronously; the partial word is lost.

Test Plan:
1. Four-byte pack: bytes 0x11,0x22,0x33,0x44 on consecutive cycles, word_ready_i=1 -> word_o=0x44332211, word_bytes_o=4, word_valid_o high for 1 cycle, 1 cycle after the 4th accept.
2. Timeout: TIMEOUT_CYCLES=16, bytes 0xA5,0x5A, then none -> word_valid_o rises 16 edges after the 2nd accept; word_o=0x00005AA5; word_bytes_o=2.
3. Backpressure: word_ready_i=0 for 10 cycles with a full word pending -> rx_d_ready_o=0 and word_o stable throughout; after the handshake the next byte is accepted, with no byte lost from a continuous FIFO stream.
4. Errors and IRQ:
   - parity_err_i pulse -> err_sticky_o=3'b010; irq_o=1 when irq_err_en_i=1, and irq_o=0 when irq_err_en_i=0.
   - err_clr_i=3'b010 in the same cycle as a new parity pulse -> flag stays 1.
5. Flush: flush_i after 3 bytes -> flush_rx_o one-cycle pulse; no word emitted; the next 4 bytes form a fresh word with byte0 in [7:0].
6. Async reset: assert rst_n low mid-FILL, between clock edges -> all outputs go to their reset values immediately; after release, the first byte lands in word_o[7:0].
